// File: rtl/logic_gate_pipe_if.sv
// rtl/logic_gate_pipe_if.sv - operand/result handshake bundle for logic_gate_pipe; parity member exists only with LOGIC_PARITY_EN
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic [15:0]      done_cnt;
`ifdef LOGIC_PARITY_EN
    logic             parity;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, o, done_cnt, parity
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, o, done_cnt, parity
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, o, done_cnt
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, o, done_cnt
    );
`endif
endinterface

// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - pipelined eight-function bitwise unit with elastic valid/ready stages; LOGIC_PARITY_EN adds registered parity of o
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    logic_gate_pipe_if.slave bus
);

    logic [WIDTH-1:0]  f_res;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [15:0]       done_cnt_q, done_cnt_d;
`ifdef LOGIC_PARITY_EN
    logic [STAGES-1:0] p_q, p_d;
`endif

    // Bitwise function of the operands currently offered at the input
    always_comb begin
        case (bus.op)
            3'b000:  f_res = ~bus.a;
            3'b001:  f_res = bus.a & bus.b;
            3'b010:  f_res = bus.a | bus.b;
            3'b011:  f_res = bus.a ^ bus.b;
            3'b100:  f_res = ~(bus.a & bus.b);
            3'b101:  f_res = ~(bus.a | bus.b);
            3'b110:  f_res = ~(bus.a ^ bus.b);
            default: f_res = bus.a;
        endcase
    end

    // Ready chain: a stage can take a beat if it is empty or its successor moves
    always_comb begin
        logic r;
        ready = '0;
        r     = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r        = ~v_q[i] | r;
            ready[i] = r;
        end
    end

    // Stage advance; data regs only load real beats so o stays put across bubbles
    always_comb begin
        v_d = v_q;
        d_d = d_q;
`ifdef LOGIC_PARITY_EN
        p_d = p_q;
`endif
        if (ready[0]) begin
            v_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                d_d[0] = f_res;
`ifdef LOGIC_PARITY_EN
                p_d[0] = ^f_res;
`endif
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (ready[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
`ifdef LOGIC_PARITY_EN
                    p_d[i] = p_q[i-1];
`endif
                end
            end
        end
    end

    // Hand-off counter, wraps naturally at 16 bits
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (v_q[STAGES-1] && bus.out_ready) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    // State registers; reset discards every in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            done_cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
`ifdef LOGIC_PARITY_EN
            p_q        <= '0;
`endif
        end else begin
            v_q        <= v_d;
            d_q        <= d_d;
            done_cnt_q <= done_cnt_d;
`ifdef LOGIC_PARITY_EN
            p_q        <= p_d;
`endif
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.o         = d_q[STAGES-1];
    assign bus.done_cnt  = done_cnt_q;
`ifdef LOGIC_PARITY_EN
    assign bus.parity    = p_q[STAGES-1];
`endif

endmodule
